uart_rx: RTL

UART receiver for the serial console path. It consumes the 16x oversampling tick from the baud tick generator (`b_tick`), recovers 8N1 frames from the asynchronous `rx` pin and presents each received byte with a one-cycle strobe. It feeds the RX FIFO / command decoder. It has no handshake back-pressure: the downstream block must accept `rx_data` on the `rx_done` cycle.

---
 rtl/uart_rx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (parameterisable) UART receiver driven by an oversampling tick.
// Recovers frames from the asynchronous rx pin, presents each good byte with a
// one-cycle rx_done strobe and flags bad stop bits with a one-cycle frame_err.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling data bits at mid-bit, LSB first
// STOP  | sampling the stop bit and reporting the frame result
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;

  logic rx_meta;
  logic rx_s;
  logic rx_d;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection;
  // all reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Frame FSM with tick counter, bit counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // Edge detection ignores b_tick, so a coincident tick is not counted.
          if (rx_d && !rx_s) begin
            state   <= START;
            tcnt    <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (b_tick) begin
            if (tcnt == T_MID) begin
              tcnt <= '0;
              if (!rx_s) begin
                state <= DATA;
                bcnt  <= '0;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (b_tick) begin
            if (tcnt == T_END) begin
              tcnt  <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              bcnt  <= bcnt + BW'(1);
              if (bcnt == B_LAST) begin
                state <= STOP;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (b_tick) begin
            if (tcnt == T_END) begin
              tcnt    <= '0;
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (rx_s) begin
                rx_data <= shreg;
                rx_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
